// File: rtl/alu_issue_unit_pkg.sv
// alu_issue_unit_pkg: op codes, FSM states and widths shared by the issue stage
package alu_issue_unit_pkg;
  localparam int WIDTH = 4;
  localparam int AW = 2;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b001;
  localparam logic [2:0] OP_OR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_LOADI = 3'b111;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/alu.sv
// alu: 4-bit signed combinational ALU (AND/NAND/OR/NOR/ADD/SUB/SLT)
module alu (
  input  logic signed [3:0] a,
  input  logic signed [3:0] b,
  input  logic [2:0]        control,
  output logic signed [3:0] res
);
  always_comb begin
    res = '0;
    case (control)
      3'b000: res = a & b;
      3'b001: res = ~(a & b);
      3'b010: res = a | b;
      3'b011: res = ~(a | b);
      3'b100: res = a + b;
      3'b101: res = a - b;
      3'b110: res = {3'b000, a < b};
      default: res = '0;
    endcase
  end
endmodule

// File: rtl/alu_issue_unit_regfile.sv
// regfile4x4: 4x4-bit register array, one sync write port, three async read ports
module regfile4x4
  import alu_issue_unit_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_rs_addr,
  input  logic [AW-1:0]    i_rt_addr,
  input  logic [AW-1:0]    i_dbg_addr,
  output logic [WIDTH-1:0] o_rs_data,
  output logic [WIDTH-1:0] o_rt_data,
  output logic [WIDTH-1:0] o_dbg_data
);
  logic [WIDTH-1:0] r_mem [4];
  always_ff @(posedge clk) begin
    if (reset) r_mem <= '{default: '0};
    else if (i_we) r_mem[i_waddr] <= i_wdata;
  end
  assign o_rs_data = r_mem[i_rs_addr];
  assign o_rt_data = r_mem[i_rt_addr];
  assign o_dbg_data = r_mem[i_dbg_addr];
endmodule

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: one-at-a-time issue stage feeding the 4-bit alu with write-back
module alu_issue_unit
  import alu_issue_unit_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [AW-1:0]    in_rd,
  input  logic [AW-1:0]    in_rs,
  input  logic [AW-1:0]    in_rt,
  input  logic [WIDTH-1:0] in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_rd,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);
  state_t           r_state, w_next;
  logic [2:0]       r_op, w_ctrl;
  logic [AW-1:0]    r_rd, r_out_rd;
  logic [WIDTH-1:0] r_a, r_b, r_imm, r_out_data;
  logic [WIDTH-1:0] w_rs_data, w_rt_data, w_alu_res, w_result;
  logic             w_accept, w_we;
  always_comb begin
    w_next = r_state;
    w_accept = (r_state == IDLE) && in_valid;
    w_we = r_state == EXEC;
    w_next = w_accept ? EXEC : w_we ? RESP : (r_state == RESP && out_ready) ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_op <= '0;
      r_rd <= '0;
      r_a <= '0;
      r_b <= '0;
      r_imm <= '0;
      r_out_data <= '0;
      r_out_rd <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op <= in_op;
        r_rd <= in_rd;
        r_a <= w_rs_data;
        r_b <= w_rt_data;
        r_imm <= in_imm;
      end
      if (w_we) begin
        r_out_data <= w_result;
        r_out_rd <= r_rd;
      end
    end
  end
  // LOADI must never reach the ALU as 111, so it rides through as AND
  assign w_ctrl = (r_op == OP_LOADI) ? OP_AND : r_op;
  assign w_result = (r_op == OP_LOADI) ? r_imm : w_alu_res;
  assign in_ready = r_state == IDLE;
  assign out_valid = r_state == RESP;
  assign out_data = r_out_data;
  assign out_rd = r_out_rd;
  alu u_alu (
    .a(r_a),
    .b(r_b),
    .control(w_ctrl),
    .res(w_alu_res)
  );
  regfile4x4 u_rf (
    .clk(clk),
    .reset(reset),
    .i_we(w_we),
    .i_waddr(r_rd),
    .i_wdata(w_result),
    .i_rs_addr(in_rs),
    .i_rt_addr(in_rt),
    .i_dbg_addr(dbg_addr),
    .o_rs_data(w_rs_data),
    .o_rt_data(w_rt_data),
    .o_dbg_data(dbg_data)
  );
endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: scoreboard bench for the ALU issue stage
module tb_alu_issue_unit;
  import alu_issue_unit_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [2:0] in_op = '0;
  logic [1:0] in_rd = '0, in_rs = '0, in_rt = '0, out_rd, dbg_addr = '0;
  logic [3:0] in_imm = '0, out_data, dbg_data;
  int checks = 0, failures = 0;
  logic [3:0] m_rf [4] = '{default: '0};
  logic [5:0] sb [$];
  always #5 clk = ~clk;
  alu_issue_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
  function automatic logic [3:0] model(logic [2:0] op, logic [3:0] a, logic [3:0] b, logic [3:0] imm);
    case (op)
      3'b000: return a & b;
      3'b001: return ~(a & b);
      3'b010: return a | b;
      3'b011: return ~(a | b);
      3'b100: return a + b;
      3'b101: return a - b;
      3'b110: return {3'b000, $signed(a) < $signed(b)};
      default: return imm;
    endcase
  endfunction
  task automatic send(input logic [2:0] op, input logic [1:0] rd, rs, rt, input logic [3:0] imm);
    logic [3:0] r;
    @(negedge clk);
    in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_imm = imm; in_valid = 1'b1;
    @(posedge clk);
    r = model(op, m_rf[rs], m_rf[rt], imm);
    m_rf[rd] = r;
    sb.push_back({rd, r});
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic collect(output logic ok, output logic [5:0] got, output logic [5:0] exp);
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (out_valid) ok = 1'b1;
      else @(negedge clk);
    end
    got = {out_rd, out_data};
    exp = sb.size() > 0 ? sb.pop_front() : 6'bx;
    if (ok) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask
  task automatic run_table(input logic [16:0] tbl [$], input string name);
    logic ok;
    logic [5:0] got, exp;
    foreach (tbl[k]) begin
      send(tbl[k][16:14], tbl[k][13:12], tbl[k][11:10], tbl[k][9:8], tbl[k][7:4]);
      collect(ok, got, exp);
      checks++;
      if (!ok || got !== exp) begin
        failures++;
        $display("FAIL %s[%0d] out: got valid=%0b rd/data=%h want %h", name, k, ok, got, exp);
      end
      dbg_addr = tbl[k][13:12];
      #1;
      checks++;
      if (dbg_data !== tbl[k][3:0]) begin
        failures++;
        $display("FAIL %s[%0d] dbg r%0d: got %b want %b", name, k, dbg_addr, dbg_data, tbl[k][3:0]);
      end
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({in_ready, out_valid, out_data, out_rd} !== 8'b1000_0000) begin
      failures++;
      $display("FAIL reset outputs: got rdy=%b v=%b d=%b rd=%b want 1 0 0000 00", in_ready, out_valid, out_data, out_rd);
    end
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      checks++;
      if (dbg_data !== 4'b0000) begin
        failures++;
        $display("FAIL reset r%0d: got %b want 0000", i, dbg_data);
      end
    end
  endtask
  task automatic test_arith;
    logic [16:0] tbl [$];
    tbl = '{{OP_LOADI, 2'd1, 2'd0, 2'd0, 4'b0101, 4'b0101},
            {OP_LOADI, 2'd2, 2'd0, 2'd0, 4'b0011, 4'b0011},
            {OP_ADD, 2'd3, 2'd1, 2'd2, 4'b0000, 4'b1000},
            {OP_SUB, 2'd0, 2'd2, 2'd1, 4'b0000, 4'b1110},
            {OP_SLT, 2'd3, 2'd1, 2'd2, 4'b0000, 4'b0000},
            {OP_SLT, 2'd3, 2'd2, 2'd1, 4'b0000, 4'b0001},
            {OP_LOADI, 2'd1, 2'd0, 2'd0, 4'b1000, 4'b1000},
            {OP_SLT, 2'd0, 2'd1, 2'd2, 4'b0000, 4'b0001}};
    run_table(tbl, "arith");
  endtask
  task automatic test_raw;
    logic [16:0] tbl [$];
    tbl = '{{OP_LOADI, 2'd0, 2'd0, 2'd0, 4'b0000, 4'b0000},
            {OP_LOADI, 2'd1, 2'd0, 2'd0, 4'b0111, 4'b0111},
            {OP_NAND, 2'd1, 2'd1, 2'd1, 4'b0000, 4'b1000},
            {OP_OR, 2'd2, 2'd1, 2'd0, 4'b0000, 4'b1000},
            {OP_NOR, 2'd0, 2'd0, 2'd0, 4'b1111, 4'b1111}};
    run_table(tbl, "raw");
  endtask
  task automatic test_latency;
    logic [5:0] exp;
    out_ready = 1'b1;
    send(OP_ADD, 2'd3, 2'd1, 2'd2, 4'b0000);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat N: got rdy=%b v=%b want 0 0", in_ready, out_valid);
    end
    @(negedge clk);
    exp = sb.pop_front();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || {out_rd, out_data} !== exp) begin
      failures++;
      $display("FAIL lat N+1: got rdy=%b v=%b rd/data=%h want 0 1 %h", in_ready, out_valid, {out_rd, out_data}, exp);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat N+2: got rdy=%b v=%b want 1 0", in_ready, out_valid);
    end
    out_ready = 1'b0;
  endtask
  task automatic test_backpressure;
    logic ok;
    logic [5:0] exp;
    send(OP_SUB, 2'd0, 2'd1, 2'd2, 4'b0000);
    @(negedge clk);
    exp = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      in_rs = in_rs + 2'd1;
      in_op = OP_LOADI; in_rd = 2'(i); in_imm = 4'hA;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_rd, out_data} !== exp) begin
        failures++;
        $display("FAIL bp cyc%0d: got v=%b rdy=%b rd/data=%h want 1 0 %h", i, out_valid, in_ready, {out_rd, out_data}, exp);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      checks++;
      if (dbg_data !== m_rf[i]) begin
        failures++;
        $display("FAIL bp r%0d: got %b want %b", i, dbg_data, m_rf[i]);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    ok = in_ready === 1'b1 && out_valid === 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bp release: got rdy=%b v=%b want 1 0", in_ready, out_valid);
    end
  endtask
  task automatic test_reset_exec;
    logic ok;
    logic [5:0] got, exp;
    send(OP_LOADI, 2'd3, 2'd0, 2'd0, 4'b0110);
    collect(ok, got, exp);
    checks++;
    if (!ok || got !== exp) begin
      failures++;
      $display("FAIL rexec seed: got valid=%0b rd/data=%h want %h", ok, got, exp);
    end
    send(OP_ADD, 2'd3, 2'd1, 2'd2, 4'b0000);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_rf = '{default: '0};
    sb.delete();
    checks++;
    if ({in_ready, out_valid, out_data, out_rd} !== 8'b1000_0000) begin
      failures++;
      $display("FAIL rexec outputs: got rdy=%b v=%b d=%b rd=%b want 1 0 0000 00", in_ready, out_valid, out_data, out_rd);
    end
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      checks++;
      if (dbg_data !== 4'b0000) begin
        failures++;
        $display("FAIL rexec r%0d: got %b want 0000", i, dbg_data);
      end
    end
    @(negedge clk);
    dbg_addr = 2'd3;
    #1;
    checks++;
    if (out_valid !== 1'b0 || dbg_data !== 4'b0000) begin
      failures++;
      $display("FAIL rexec after: got v=%b r3=%b want 0 0000", out_valid, dbg_data);
    end
  endtask
  initial begin
    test_reset();
    test_arith();
    test_raw();
    test_latency();
    test_backpressure();
    test_reset_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
